// File: rtl/vga_pattern_generator_if.sv
// Pixel-side bundle between the display timing controller and the pattern
// generator: timing/coordinate inputs and the re-timed VGA outputs.
interface vga_pattern_generator_if;
  logic [1:0] mode_sel;
  logic       hs_in;
  logic       vs_in;
  logic       active_in;
  logic [9:0] x_in;
  logic [9:0] y_in;
  logic       hs_out;
  logic       vs_out;
  logic [3:0] r;
  logic [3:0] g;
  logic [3:0] b;
  logic [7:0] frame_cnt;

  // Timing controller / bench side.
  modport master (
    output mode_sel, hs_in, vs_in, active_in, x_in, y_in,
    input  hs_out, vs_out, r, g, b, frame_cnt
  );

  // Pattern generator side.
  modport slave (
    input  mode_sel, hs_in, vs_in, active_in, x_in, y_in,
    output hs_out, vs_out, r, g, b, frame_cnt
  );
endinterface

// File: rtl/vga_pattern_generator.sv
// VGA test pattern generator: colour bars, checkerboard, gradient and a
// bouncing box, two pipeline stages behind the timing controller.
// Optional macro PATTERN_BORDER_EN: forces a one-pixel white frame around
// the active area in every mode without changing latency.
module vga_pattern_generator #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int BOX_SIZE   = 32,
  parameter int STEP       = 4,
  parameter int CHECK_LOG2 = 5,
  parameter bit SYNC_IDLE  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  vga_pattern_generator_if.slave bus
);

  localparam int          STAGES = 2;
  localparam int          BAR_W  = H_ACTIVE / 8;
  localparam logic [10:0] XMAX   = 11'(H_ACTIVE - BOX_SIZE);
  localparam logic [10:0] YMAX   = 11'(V_ACTIVE - BOX_SIZE);
  localparam logic [10:0] STEP11 = 11'(STEP);
  localparam logic [10:0] BOX11  = 11'(BOX_SIZE);

  // Box position on one axis; neg=1 means moving toward 0.
  typedef struct packed {
    logic        neg;
    logic [10:0] pos;
  } axis_t;

  // Stage-1 payload: only what stage 2 actually needs to colour a pixel.
  typedef struct packed {
    logic [7:0] grad;   // {x[9:6], y[8:5]}
    logic [2:0] bar;
    logic       chk;
    logic       hit;
`ifdef PATTERN_BORDER_EN
    logic       edge_px;
`endif
  } s1_t;

  // One frame of box motion: clamp at the wall and reverse on the frame
  // that would overshoot.
  function automatic axis_t axis_next(input axis_t cur, input logic [10:0] maxv);
    axis_t nxt;
    nxt = cur;
    if (!cur.neg) begin
      if (cur.pos + STEP11 > maxv) begin
        nxt.pos = maxv;
        nxt.neg = 1'b1;
      end else begin
        nxt.pos = cur.pos + STEP11;
      end
    end else begin
      if (cur.pos < STEP11) begin
        nxt.pos = '0;
        nxt.neg = 1'b0;
      end else begin
        nxt.pos = cur.pos - STEP11;
      end
    end
    return nxt;
  endfunction

  function automatic logic [11:0] bar_colour(input logic [2:0] idx);
    logic [11:0] c;
    unique case (idx)
      3'd0:    c = 12'hFFF;
      3'd1:    c = 12'hFF0;
      3'd2:    c = 12'h0FF;
      3'd3:    c = 12'h0F0;
      3'd4:    c = 12'hF0F;
      3'd5:    c = 12'hF00;
      3'd6:    c = 12'h00F;
      default: c = 12'h000;
    endcase
    return c;
  endfunction

  logic [STAGES:1] vld_pipe;
  logic            hs_q, vs_q;
  logic            armed;
  logic            frame_start;
  logic [1:0]      mode_q;
  logic [7:0]      frame_cnt_q;
  axis_t           box_x_q, box_y_q;
  s1_t             s1_d, s1_q;
  logic [11:0]     rgb_d, rgb_q;
  logic [31:0]     x_w;
  logic [10:0]     x11, y11;

  assign x_w = {22'd0, bus.x_in};
  assign x11 = {1'b0, bus.x_in};
  assign y11 = {1'b0, bus.y_in};

  // Leading edge of vsync; suppressed on the first cycle out of reset so a
  // reset released during vsync does not count as a new frame.
  assign frame_start = armed && (bus.vs_in == !SYNC_IDLE) && (vs_q == SYNC_IDLE);

  // Per-pixel pattern decode feeding the stage-1 register.
  always_comb begin
    s1_d      = '0;
    s1_d.grad = {bus.x_in[9:6], bus.y_in[8:5]};
    // Comparison chain instead of x/BAR_W: last hit (lowest bar) wins.
    s1_d.bar  = 3'd7;
    for (int i = 6; i >= 0; i--) begin
      if (x_w < 32'(BAR_W * (i + 1))) s1_d.bar = 3'(i);
    end
    s1_d.chk  = bus.x_in[CHECK_LOG2] ^ bus.y_in[CHECK_LOG2];
    s1_d.hit  = (x11 >= box_x_q.pos) && (x11 < box_x_q.pos + BOX11) &&
                (y11 >= box_y_q.pos) && (y11 < box_y_q.pos + BOX11);
`ifdef PATTERN_BORDER_EN
    s1_d.edge_px = (bus.x_in == 10'(0)) || (bus.x_in == 10'(H_ACTIVE - 1)) ||
                   (bus.y_in == 10'(0)) || (bus.y_in == 10'(V_ACTIVE - 1));
`endif
  end

  // Stage 1: valid shift, one-cycle sync delay, decode capture on active pixels.
  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_pipe <= '0;
      hs_q     <= SYNC_IDLE;
      vs_q     <= SYNC_IDLE;
      s1_q     <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], bus.active_in};
      hs_q     <= bus.hs_in;
      vs_q     <= bus.vs_in;
      if (bus.active_in) s1_q <= s1_d;
    end
  end

  // Per-frame state: mode latch, frame counter and box motion.
  always_ff @(posedge clk) begin
    if (!rst) begin
      armed       <= 1'b0;
      mode_q      <= 2'd0;
      frame_cnt_q <= 8'd0;
      box_x_q     <= '0;
      box_y_q     <= '0;
    end else begin
      armed <= 1'b1;
      if (frame_start) begin
        mode_q      <= bus.mode_sel;
        frame_cnt_q <= frame_cnt_q + 8'd1;
        box_x_q     <= axis_next(box_x_q, XMAX);
        box_y_q     <= axis_next(box_y_q, YMAX);
      end
    end
  end

  // Colour select from the latched mode and the stage-1 decode.
  always_comb begin
    rgb_d = 12'h000;
    unique case (mode_q)
      2'd0:    rgb_d = bar_colour(s1_q.bar);
      2'd1:    rgb_d = s1_q.chk ? 12'hFFF : 12'h000;
      2'd2:    rgb_d = {s1_q.grad, frame_cnt_q[5:2]};
      default: rgb_d = s1_q.hit ? 12'hFFF : 12'h00F;
    endcase
`ifdef PATTERN_BORDER_EN
    if (s1_q.edge_px) rgb_d = 12'hFFF;
`endif
  end

  // Stage 2: colour register.
  always_ff @(posedge clk) begin
    if (!rst) rgb_q <= 12'h000;
    else      rgb_q <= rgb_d;
  end

  assign bus.hs_out               = hs_q;
  assign bus.vs_out               = vs_q;
  assign {bus.r, bus.g, bus.b}    = vld_pipe[STAGES] ? rgb_q : 12'h000;
  assign bus.frame_cnt            = frame_cnt_q;

endmodule
